// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one ALU between NUM_REQ requesters, one-entry response buffer.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
package mypkg;
  typedef enum logic [3:0] {
    A_ADD  = 4'd0,
    A_SUB  = 4'd1,
    A_AND  = 4'd2,
    A_OR   = 4'd3,
    A_XOR  = 4'd4,
    A_SLL  = 4'd5,
    A_SRL  = 4'd6,
    A_SRA  = 4'd7,
    A_SLT  = 4'd8,
    A_SLTU = 4'd9
  } alu_op_e;
endpackage

module alu_share_arb
  import mypkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  alu_op_e [NUM_REQ-1:0]    req_op_i,
  input  logic [NUM_REQ-1:0][31:0] req_a_i,
  input  logic [NUM_REQ-1:0][31:0] req_b_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [31:0]              rsp_data_o,
  output logic                     rsp_nz_o,
  output alu_op_e                  alu_op_o,
  output logic [31:0]              alu_a_o,
  output logic [31:0]              alu_b_o,
  input  logic [31:0]              alu_data_i,
  input  logic                     alu_nz_i
);
  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [31:0]        data_q, data_d;
  logic               nz_q, nz_d;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    cand;
  logic               any_gnt;
  logic               space;
  logic               accept;
  logic [NUM_REQ-1:0] gnt;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]    last_q, last_d;
`endif

  always_comb begin
    any_gnt = 1'b0;
    gnt_idx = '0;
    cand    = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ID_W'(i);
      if (req_valid_i[cand]) begin
        any_gnt = 1'b1;
        gnt_idx = cand;
      end
    end
`else
    // Scan backwards so the port closest after last_q is written last and wins.
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(last_q) + i) % NUM_REQ);
      if (req_valid_i[cand]) begin
        any_gnt = 1'b1;
        gnt_idx = cand;
      end
    end
`endif
  end

  always_comb begin
    gnt = '0;
    if (any_gnt) gnt[gnt_idx] = 1'b1;
  end

  assign space       = rst_ni & ((state_q == S_EMPTY) | rsp_ready_i);
  assign req_ready_o = gnt & {NUM_REQ{space}};
  assign accept      = |(req_valid_i & req_ready_o);

  always_comb begin
    alu_op_o = A_ADD;
    alu_a_o  = '0;
    alu_b_o  = '0;
    if (any_gnt) begin
      alu_op_o = req_op_i[gnt_idx];
      alu_a_o  = req_a_i[gnt_idx];
      alu_b_o  = req_b_i[gnt_idx];
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    data_d  = data_q;
    nz_d    = nz_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    if (accept) begin
      state_d = S_FULL;
      id_d    = gnt_idx;
      data_d  = alu_data_i;
      nz_d    = alu_nz_i;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_d  = gnt_idx;
`endif
    end else if (state_q == S_FULL && rsp_ready_i) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      id_q    <= '0;
      data_q  <= '0;
      nz_q    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      data_q  <= data_d;
      nz_q    <= nz_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign rsp_valid_o = (state_q == S_FULL);
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = data_q;
  assign rsp_nz_o    = nz_q;

endmodule
